instruction_fetch: RTL and testbench

- Fetch stage directly downstream of the program-counter register.
- Takes the current PC, reads the instruction from a loadable word-addressed instruction memory, and latches instruction and PC+4 into the IF/ID pipeline register.
- Computes the next-PC value fed back to the PC register: sequential, branch or jump redirect, stall hold, or halt hold.
- Owns the fetch run/halt state machine used by the debug unit.

---
 rtl/instruction_fetch.sv | 159 +++++++++++++++
 tb/tb_instruction_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: word-addressed loadable instruction memory, IF/ID
// pipeline register, next-PC selection and the IDLE/RUN/HALTED fetch FSM.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_pc                 current PC from the PC register
//   o_npc                next PC to the PC register (combinational)
//   i_start              IDLE->RUN request
//   i_enable             fetch advance enable (level or single-step pulse)
//   i_stall              load-use hazard, hold PC and IF/ID
//   i_branch_taken/_target, i_jump/_target   redirect requests (jump wins)
//   i_load_we/_addr/_data                    instruction memory write port (IDLE only)
//   o_instr, o_pc4, o_valid                  IF/ID register
//   o_halted             fetch FSM is in HALTED
module instruction_fetch #(
    parameter int unsigned      NBITS     = 32,
    parameter int unsigned      MEM_DEPTH = 256,
    parameter int unsigned      ADDR_BITS = 8,
    parameter logic [NBITS-1:0] HALT_CODE = {NBITS{1'b1}}
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NBITS-1:0]     i_pc,
    output logic [NBITS-1:0]     o_npc,
    input  logic                 i_start,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [NBITS-1:0]     i_branch_target,
    input  logic                 i_jump,
    input  logic [NBITS-1:0]     i_jump_target,
    input  logic                 i_load_we,
    input  logic [ADDR_BITS-1:0] i_load_addr,
    input  logic [NBITS-1:0]     i_load_data,
    output logic [NBITS-1:0]     o_instr,
    output logic [NBITS-1:0]     o_pc4,
    output logic                 o_valid,
    output logic                 o_halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] instr_q, instr_d;
    logic [NBITS-1:0] pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;

    logic [NBITS-1:0] mem_q [MEM_DEPTH];

    logic [ADDR_BITS-1:0] word_idx_c;
    logic                 out_of_range_c;
    logic [NBITS-1:0]     fetch_word_c;
    logic [NBITS-1:0]     pc_plus4_c;
    logic                 is_halt_c;
    logic                 advance_c;
    logic                 redirect_c;
    logic                 load_en_c;

    // Combinational read; any PC beyond the memory fetches HALT so a runaway stops.
    assign word_idx_c     = i_pc[ADDR_BITS+1:2];
    assign out_of_range_c = |i_pc[NBITS-1:ADDR_BITS+2];
    assign fetch_word_c   = out_of_range_c ? HALT_CODE : mem_q[word_idx_c];
    assign pc_plus4_c     = i_pc + NBITS'(4);
    assign is_halt_c      = (fetch_word_c == HALT_CODE);
    assign advance_c      = (state_q == S_RUN) && i_enable;
    assign redirect_c     = i_jump || i_branch_taken;
    assign load_en_c      = i_load_we && (state_q == S_IDLE);

    // Program load port, only open while idle; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (load_en_c) begin
            mem_q[i_load_addr] <= i_load_data;
        end
    end

    // Next PC: purely from i_pc and control inputs plus state.
    always_comb begin
        o_npc = i_pc;
        if (advance_c) begin
            if (i_jump) begin
                o_npc = i_jump_target;
            end else if (i_branch_taken) begin
                o_npc = i_branch_target;
            end else if (i_stall || is_halt_c) begin
                o_npc = i_pc;
            end else begin
                o_npc = pc_plus4_c;
            end
        end
    end

    // Fetch FSM and IF/ID next-state.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (i_enable) begin
                    if (redirect_c) begin
                        // Flush the wrong-path fetch; pc4 is left as is.
                        instr_d = '0;
                        valid_d = 1'b0;
                    end else if (!i_stall) begin
                        instr_d = fetch_word_c;
                        pc4_d   = pc_plus4_c;
                        valid_d = 1'b1;
                        if (is_halt_c) begin
                            state_d  = S_HALTED;
                            halted_d = 1'b1;
                        end
                    end
                end
            end
            S_HALTED: begin
                // Drain: keep feeding bubbles behind the retired HALT.
                instr_d = '0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            pc4_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign o_instr  = instr_q;
    assign o_pc4    = pc4_q;
    assign o_valid  = valid_q;
    assign o_halted = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed sequence plus randomized control,
// checked against a behavioural model of the fetch stage. The bench also
// plays the PC register, feeding the model's next PC back as i_pc.
module tb_instruction_fetch;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pc;
    logic [31:0] o_npc;
    logic        i_start;
    logic        i_enable;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_jump;
    logic [31:0] i_jump_target;
    logic        i_load_we;
    logic [7:0]  i_load_addr;
    logic [31:0] i_load_data;
    logic [31:0] o_instr;
    logic [31:0] o_pc4;
    logic        o_valid;
    logic        o_halted;

    instruction_fetch dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_pc            (i_pc),
        .o_npc           (o_npc),
        .i_start         (i_start),
        .i_enable        (i_enable),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_load_we       (i_load_we),
        .i_load_addr     (i_load_addr),
        .i_load_data     (i_load_data),
        .o_instr         (o_instr),
        .o_pc4           (o_pc4),
        .o_valid         (o_valid),
        .o_halted        (o_halted)
    );

    always #5 i_clk = ~i_clk;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state.
    logic [31:0] m_mem [256];
    bit          m_run;
    bit          m_halted;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_fetch(input logic [31:0] pc);
        if (pc >= 32'd1024) return HALT;
        return m_mem[pc[9:2]];
    endfunction

    function automatic logic [31:0] ref_npc();
        if (!m_run || !i_enable) return i_pc;
        if (i_jump) return i_jump_target;
        if (i_branch_taken) return i_branch_target;
        if (i_stall) return i_pc;
        if (ref_fetch(i_pc) == HALT) return i_pc;
        return i_pc + 32'd4;
    endfunction

    // One clock: check o_npc before the edge, advance model, check IF/ID after.
    task automatic tick(input bit follow);
        logic [31:0] npc;
        logic [31:0] w;
        #1;
        npc = ref_npc();
        check("npc", o_npc, npc);
        w = ref_fetch(i_pc);
        @(posedge i_clk);
        #1;
        if (i_reset) begin
            m_run = 0; m_halted = 0; m_instr = '0; m_pc4 = '0; m_valid = 0;
        end else if (m_halted) begin
            m_instr = '0; m_valid = 0;
        end else if (m_run) begin
            if (i_enable) begin
                if (i_jump || i_branch_taken) begin
                    m_instr = '0; m_valid = 0;
                end else if (!i_stall) begin
                    m_instr = w; m_pc4 = i_pc + 32'd4; m_valid = 1;
                    if (w == HALT) begin
                        m_run = 0; m_halted = 1;
                    end
                end
            end
        end else begin
            if (i_load_we) m_mem[i_load_addr] = i_load_data;
            if (i_start) m_run = 1;
        end
        check("instr", o_instr, m_instr);
        check("pc4", o_pc4, m_pc4);
        check("valid", 32'(o_valid), 32'(m_valid));
        check("halted", 32'(o_halted), 32'(m_halted));
        if (follow) i_pc = npc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] prog [3];
        prog[0] = 32'h2001_0005;
        prog[1] = 32'h2002_0007;
        prog[2] = HALT;

        i_reset = 1; i_pc = '0; i_start = 0; i_enable = 0; i_stall = 0;
        i_branch_taken = 0; i_branch_target = '0; i_jump = 0; i_jump_target = '0;
        i_load_we = 0; i_load_addr = '0; i_load_data = '0;
        m_run = 0; m_halted = 0; m_instr = '0; m_pc4 = '0; m_valid = 0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_instr", o_instr, 32'h0);
        check("rst_pc4", o_pc4, 32'h0);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_halted", 32'(o_halted), 32'h0);
        i_reset = 0;

        // Fill the whole memory: program at words 0..2, random non-HALT elsewhere.
        for (int a = 0; a < 256; a++) begin
            i_load_we   = 1;
            i_load_addr = 8'(a);
            i_load_data = (a < 3) ? prog[a] : ($urandom() & 32'h7FFF_FFFF);
            tick(0);
        end
        i_load_we = 0;

        // Load, run, halt.
        i_pc = '0; i_start = 1;
        tick(0);
        i_start = 0; i_enable = 1;
        tick(1);
        check("t1_instr0", o_instr, 32'h2001_0005);
        check("t1_pc4_0", o_pc4, 32'd4);
        tick(1);
        check("t1_instr1", o_instr, 32'h2002_0007);
        check("t1_pc4_1", o_pc4, 32'd8);
        tick(1);
        check("t1_instr2", o_instr, HALT);
        check("t1_pc4_2", o_pc4, 32'd12);
        check("t1_valid2", 32'(o_valid), 32'd1);
        check("t1_halted", 32'(o_halted), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("t1_hold_npc", o_npc, 32'd8);
            check("t1_drain_valid", 32'(o_valid), 32'd0);
        end

        // Restart after reset; memory kept.
        i_reset = 1; i_enable = 0;
        tick(0);
        i_reset = 0; i_start = 1;
        tick(0);
        i_start = 0; i_enable = 1; i_pc = '0;
        tick(1);

        // Stall at PC 4 for two cycles.
        i_stall = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t2_stall_npc", o_npc, 32'd4);
            tick(1);
            check("t2_stall_instr", o_instr, 32'h2001_0005);
            check("t2_stall_pc4", o_pc4, 32'd4);
        end
        i_stall = 0;
        #1;
        check("t2_release_npc", o_npc, 32'd8);

        // Redirect overrides stall, jump overrides branch.
        i_stall = 1; i_branch_taken = 1; i_branch_target = 32'h40;
        i_jump = 1; i_jump_target = 32'h80;
        #1;
        check("t3_npc", o_npc, 32'h80);
        tick(1);
        check("t3_flush_instr", o_instr, 32'h0);
        check("t3_flush_valid", 32'(o_valid), 32'd0);
        i_stall = 0; i_branch_taken = 0; i_jump = 0;

        // Randomized control in RUN, with blocked load attempts on word 1.
        for (int k = 0; k < 150; k++) begin
            i_enable        = ($urandom_range(4, 0) != 0);
            i_stall         = ($urandom_range(3, 0) == 0);
            i_jump          = ($urandom_range(7, 0) == 0);
            i_branch_taken  = ($urandom_range(5, 0) == 0);
            i_jump_target   = 32'($urandom_range(250, 3) * 4);
            i_branch_target = 32'($urandom_range(250, 3) * 4);
            i_load_we       = ($urandom_range(2, 0) == 0);
            i_load_addr     = 8'd1;
            i_load_data     = $urandom();
            tick(1);
        end
        i_enable = 0; i_stall = 0; i_jump = 0; i_branch_taken = 0; i_load_we = 0;

        // Single step after restart: one IF/ID update per enable pulse.
        i_reset = 1;
        tick(0);
        i_reset = 0; i_start = 1;
        tick(0);
        i_start = 0; i_pc = '0;
        for (int p = 0; p < 2; p++) begin
            i_enable = 1;
            tick(1);
            i_enable = 0;
            repeat (3) tick(1);
            check("t5_step_pc4", o_pc4, 32'(4 * (p + 1)));
        end
        check("t5_word1_kept", o_instr, 32'h2002_0007);

        // Reset mid-run, then rerun from 0.
        i_enable = 1;
        i_reset = 1;
        tick(0);
        check("t5_rst_valid", 32'(o_valid), 32'd0);
        check("t5_rst_instr", o_instr, 32'h0);
        i_reset = 0; i_enable = 0; i_start = 1;
        tick(0);
        i_start = 0; i_enable = 1; i_pc = '0;
        tick(1);
        check("t5_rerun_instr", o_instr, 32'h2001_0005);

        // Out-of-range PC fetches HALT.
        i_pc = 32'h400;
        #1;
        check("t4_oor_npc", o_npc, 32'h400);
        tick(0);
        check("t4_oor_instr", o_instr, HALT);
        check("t4_oor_valid", 32'(o_valid), 32'd1);
        check("t4_oor_halted", 32'(o_halted), 32'd1);
        repeat (2) tick(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
